// File: rtl/gate_bist_pkg.sv
// Shared types and helpers for the basic-gate bank self-test.
// Holds the checker FSM state type, gate bit positions and the reference truth table.
// Bit order of every 7-bit gate vector: 0 AND, 1 OR, 2 NOT_A, 3 XOR, 4 NAND, 5 NOR, 6 XNOR.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int GATE_AND   = 0;
  localparam int GATE_OR    = 1;
  localparam int GATE_NOT_A = 2;
  localparam int GATE_XOR   = 3;
  localparam int GATE_NAND  = 4;
  localparam int GATE_NOR   = 5;
  localparam int GATE_XNOR  = 6;
  localparam int NUM_GATES  = 7;

  // Fault-free response of the bank for one {a,b} stimulus.
  function automatic logic [NUM_GATES-1:0] expected_gates(input logic a, input logic b);
    logic [NUM_GATES-1:0] e;
    e             = '0;
    e[GATE_AND]   = a & b;
    e[GATE_OR]    = a | b;
    e[GATE_NOT_A] = ~a;
    e[GATE_XOR]   = a ^ b;
    e[GATE_NAND]  = ~(a & b);
    e[GATE_NOR]   = ~(a | b);
    e[GATE_XNOR]  = ~(a ^ b);
    return e;
  endfunction

endpackage

// File: rtl/gate_bist_checker_gate_bank.sv
// Combinational two-input gate bank: the unit exercised by gate_bist_checker.
// Purely combinational, zero latency; no flow control.
// Written gate by gate (not via expected_gates) so it stays an independent implementation.
module gate_bank
  import gate_bist_pkg::*;
(
  input  logic                 a,
  input  logic                 b,
  output logic [NUM_GATES-1:0] y
);

  // One primitive per output bit.
  always_comb begin
    y             = '0;
    y[GATE_AND]   = a & b;
    y[GATE_OR]    = a | b;
    y[GATE_NOT_A] = ~a;
    y[GATE_XOR]   = a ^ b;
    y[GATE_NAND]  = ~(a & b);
    y[GATE_NOR]   = ~(a | b);
    y[GATE_XNOR]  = ~(a ^ b);
  end

endmodule

// File: rtl/gate_bist_checker.sv
// BIST controller: walks {A,B} through 00,01,10,11, samples the gate bank and grades it.
// Latency: 4*(SETTLE_CYCLES+1) cycles from accepted start to the done pulse.
// start is only looked at in IDLE; gate_out is only looked at in CHECK.
module gate_bist_checker
  import gate_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       gate_a,
  output logic       gate_b,
  input  logic [6:0] gate_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] fail_vec,
  output logic [6:0] fail_mask
);

  // Counter is loaded with SETTLE_CYCLES-1 and runs to zero, giving SETTLE_CYCLES cycles in SETTLE.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       gate_a_q, gate_a_d;
  logic       gate_b_q, gate_b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_count_q, err_count_d;
  logic [1:0] fail_vec_q, fail_vec_d;
  logic [6:0] fail_mask_q, fail_mask_d;

  logic [6:0] exp_gates;
  logic       mismatch;

  // State register; reset drops straight back to IDLE even mid-run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETTLE;
      SETTLE:  if (cnt_q == 4'd0) state_d = CHECK;
      CHECK:   state_d = (idx_q == 2'd3) ? DONE : SETTLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values for each state.
  always_comb begin
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    gate_a_d    = gate_a_q;
    gate_b_d    = gate_b_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    fail_vec_d  = fail_vec_q;
    fail_mask_d = fail_mask_q;

    // The stimulus flops are the bank inputs, so they define the vector being graded.
    exp_gates = expected_gates(gate_a_q, gate_b_q);
    // Case inequality so an X or Z from the bank is graded as a failure.
    mismatch  = (gate_out !== exp_gates);

    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d       = 2'd0;
          cnt_d       = SETTLE_LOAD;
          gate_a_d    = 1'b0;
          gate_b_d    = 1'b0;
          busy_d      = 1'b1;
          pass_d      = 1'b0;
          err_count_d = 3'd0;
          fail_vec_d  = 2'd0;
          fail_mask_d = 7'd0;
        end
      end
      SETTLE: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      end
      CHECK: begin
        if (mismatch) begin
          // Only four vectors per run, so the count tops out at 4 without wrapping.
          err_count_d = err_count_q + 3'd1;
          if (err_count_q == 3'd0) begin
            fail_vec_d  = {gate_a_q, gate_b_q};
            fail_mask_d = exp_gates ^ gate_out;
          end
        end
        if (idx_q != 2'd3) begin
          idx_d              = idx_q + 2'd1;
          {gate_a_d, gate_b_d} = idx_q + 2'd1;
          cnt_d              = SETTLE_LOAD;
        end else begin
          gate_a_d = 1'b0;
          gate_b_d = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          pass_d   = (err_count_d == 3'd0);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers; nothing from a partial run survives reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= 2'd0;
      cnt_q       <= 4'd0;
      gate_a_q    <= 1'b0;
      gate_b_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= 3'd0;
      fail_vec_q  <= 2'd0;
      fail_mask_q <= 7'd0;
    end else begin
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      gate_a_q    <= gate_a_d;
      gate_b_q    <= gate_b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      fail_vec_q  <= fail_vec_d;
      fail_mask_q <= fail_mask_d;
    end
  end

  assign gate_a    = gate_a_q;
  assign gate_b    = gate_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign fail_vec  = fail_vec_q;
  assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_gate_bist_checker.sv
// Bench for gate_bist_checker: two checkers (SETTLE_CYCLES 1 and 3), each driving its own gate bank.
// A cycle-count model grades every run from a per-gate truth-table column and is compared every cycle.
// Fault modes: 0 none, 1 AND stuck-at-0, 2 XOR/XNOR swapped, 3 NOR wrong in SETTLE only, 4 random noise.
module tb_gate_bist_checker;
  import gate_bist_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_i [2];
  logic       ga      [2];
  logic       gb      [2];
  logic       busy    [2];
  logic       done    [2];
  logic       pass    [2];
  logic [2:0] errc    [2];
  logic [1:0] fvec    [2];
  logic [6:0] fmask   [2];
  logic [6:0] bank_y  [2];
  logic [6:0] gout    [2];
  logic [6:0] noise   [2];
  logic       glitch  [2];
  int         mode    [2];

  int nchk = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  // Cycles per vector for each instance (SETTLE_CYCLES+1).
  int per [2] = '{2, 4};

  // Truth-table columns indexed by vector {a,b}: bit v of column g is gate g's output for vector v.
  logic [3:0] tt [7] = '{4'b1000, 4'b1110, 4'b0011, 4'b0110, 4'b0111, 4'b0001, 4'b1001};

  function automatic logic [6:0] model_exp(input int v);
    logic [6:0] e;
    for (int g = 0; g < 7; g++) e[g] = tt[g][v];
    return e;
  endfunction

  function automatic logic [6:0] fault(input logic [6:0] y, input int m, input logic g, input logic [6:0] n);
    logic [6:0] r;
    r = y;
    case (m)
      1: r[GATE_AND] = 1'b0;
      2: begin r[GATE_XOR] = y[GATE_XNOR]; r[GATE_XNOR] = y[GATE_XOR]; end
      3: r[GATE_NOR] = y[GATE_NOR] ^ g;
      4: r = y ^ n;
      default: ;
    endcase
    return r;
  endfunction

  gate_bank u_bank0 (.a(ga[0]), .b(gb[0]), .y(bank_y[0]));
  gate_bank u_bank1 (.a(ga[1]), .b(gb[1]), .y(bank_y[1]));

  assign gout[0] = fault(bank_y[0], mode[0], glitch[0], noise[0]);
  assign gout[1] = fault(bank_y[1], mode[1], glitch[1], noise[1]);

  gate_bist_checker #(.SETTLE_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_i[0]), .gate_a(ga[0]), .gate_b(gb[0]), .gate_out(gout[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(errc[0]), .fail_vec(fvec[0]),
    .fail_mask(fmask[0]));

  gate_bist_checker #(.SETTLE_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_i[1]), .gate_a(ga[1]), .gate_b(gb[1]), .gate_out(gout[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(errc[1]), .fail_vec(fvec[1]),
    .fail_mask(fmask[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. k = edges since the start-sampling edge (1-based), 0 when idle.
  int         k    [2];
  int         m_err[2];
  logic       m_pass[2];
  logic [1:0] m_fv [2];
  logic [6:0] m_fm [2];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        k[i] = 0; m_err[i] = 0; m_pass[i] = 1'b0; m_fv[i] = 2'd0; m_fm[i] = 7'd0;
      end else if (k[i] == 0) begin
        if (start_i[i] === 1'b1) begin
          k[i] = 1; m_err[i] = 0; m_pass[i] = 1'b0; m_fv[i] = 2'd0; m_fm[i] = 7'd0;
        end
      end else if (k[i] == 4 * per[i] + 1) begin
        k[i] = 0;
      end else begin
        // The last cycle of each vector's slot is its sampling cycle.
        if (k[i] % per[i] == 0) begin
          int v;
          logic [6:0] e;
          v = (k[i] - 1) / per[i];
          e = model_exp(v);
          if (gout[i] !== e) begin
            if (m_err[i] == 0) begin
              m_fv[i] = 2'(v);
              m_fm[i] = e ^ gout[i];
            end
            m_err[i]++;
          end
        end
        k[i]++;
        if (k[i] == 4 * per[i] + 1) m_pass[i] = (m_err[i] == 0);
      end
    end
  end

  // Compare every output of both instances each cycle, then refresh fault stimulus.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic       eb;
      logic [1:0] ev;
      eb = (k[i] >= 1) && (k[i] <= 4 * per[i]);
      ev = eb ? 2'((k[i] - 1) / per[i]) : 2'd0;
      if (chk_en) begin
        chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(eb));
        chk($sformatf("done%0d", i), 32'(done[i]), 32'(k[i] == 4 * per[i] + 1));
        chk($sformatf("vec%0d", i), 32'({ga[i], gb[i]}), 32'(ev));
        chk($sformatf("pass%0d", i), 32'(pass[i]), 32'(m_pass[i]));
        chk($sformatf("err_count%0d", i), 32'(errc[i]), 32'(m_err[i]));
        chk($sformatf("fail_vec%0d", i), 32'(fvec[i]), 32'(m_fv[i]));
        chk($sformatf("fail_mask%0d", i), 32'(fmask[i]), 32'(m_fm[i]));
      end
      glitch[i] = (mode[i] == 3) && eb && (k[i] % per[i] != 0);
      noise[i]  = (mode[i] == 4 && $urandom_range(0, 2) == 0) ? 7'($urandom) : 7'd0;
    end
  end

  task automatic do_run(input int i, input int m, input bit repulse, output int edges,
                        output logic [15:0] seq);
    @(negedge clk);
    mode[i] = m;
    start_i[i] = 1'b1;
    seq = '0;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start_i[i] = 1'b0;
    seq = {seq[13:0], ga[i], gb[i]};
    while (done[i] !== 1'b1 && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (busy[i] === 1'b1) seq = {seq[13:0], ga[i], gb[i]};
      start_i[i] = repulse && (done[i] !== 1'b1) && ($urandom_range(0, 3) == 0);
    end
    start_i[i] = 1'b0;
    if (done[i] !== 1'b1) chk("run_timeout", 32'(done[i]), 32'd1);
    mode[i] = 0;
  endtask

  task automatic wait_done(input int i, output int n);
    n = 0;
    while (done[i] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (done[i] !== 1'b1) chk("wait_timeout", 32'(done[i]), 32'd1);
  endtask

  initial begin
    int          edges;
    int          n;
    logic [15:0] seq;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_i[i] = 1'b0; mode[i] = 0; glitch[i] = 1'b0; noise[i] = 7'd0;
    end
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    chk("reset_outputs", 32'({ga[0], gb[0], busy[0], done[0], pass[0], errc[0], fvec[0], fmask[0]}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Fault-free, SETTLE_CYCLES=1.
    do_run(0, 0, 1'b0, edges, seq);
    chk("t1_edges", 32'(edges), 32'd9);
    chk("t1_seq", 32'(seq), 32'h05AF);
    chk("t1_pass", 32'(pass[0]), 32'd1);
    chk("t1_err", 32'(errc[0]), 32'd0);

    // AND stuck-at-0: only vector 11 fails.
    do_run(0, 1, 1'b0, edges, seq);
    chk("t2_err", 32'(errc[0]), 32'd1);
    chk("t2_vec", 32'(fvec[0]), 32'd3);
    chk("t2_mask", 32'(fmask[0]), 32'h01);
    chk("t2_pass", 32'(pass[0]), 32'd0);

    // XOR/XNOR swapped: every vector fails, first is 00.
    do_run(0, 2, 1'b0, edges, seq);
    chk("t3_err", 32'(errc[0]), 32'd4);
    chk("t3_vec", 32'(fvec[0]), 32'd0);
    chk("t3_mask", 32'(fmask[0]), 32'h48);

    // start re-pulsed mid-run, then held high through done.
    @(negedge clk);
    mode[0] = 1;
    start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    repeat (3) @(negedge clk);
    start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    @(negedge clk);
    start_i[0] = 1'b1;
    wait_done(0, n);
    chk("t4_first_err", 32'(errc[0]), 32'd1);
    @(negedge clk);
    chk("t4_idle_busy", 32'(busy[0]), 32'd0);
    chk("t4_single_done", 32'(done[0]), 32'd0);
    @(negedge clk);
    chk("t4_rearm_busy", 32'(busy[0]), 32'd1);
    chk("t4_rearm_err", 32'(errc[0]), 32'd0);
    mode[0] = 0;
    start_i[0] = 1'b0;
    wait_done(0, n);
    chk("t4_second_len", 32'(n), 32'd8);
    chk("t4_second_pass", 32'(pass[0]), 32'd1);

    // Asynchronous reset during SETTLE of vector 2.
    @(negedge clk);
    start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_pre_vec", 32'({ga[0], gb[0]}), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_vec", 32'({ga[0], gb[0]}), 32'd0);
    chk("t5_rst_busy", 32'(busy[0]), 32'd0);
    chk("t5_rst_res", 32'({done[0], pass[0], errc[0], fvec[0], fmask[0]}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_run(0, 0, 1'b0, edges, seq);
    chk("t5_after_edges", 32'(edges), 32'd9);
    chk("t5_after_pass", 32'(pass[0]), 32'd1);

    // SETTLE_CYCLES=3 with NOR disturbed only while settling.
    do_run(1, 3, 1'b0, edges, seq);
    chk("t6_edges", 32'(edges), 32'd17);
    chk("t6_pass", 32'(pass[1]), 32'd1);
    chk("t6_err", 32'(errc[1]), 32'd0);

    // Randomized runs on both instances, graded by the model every cycle.
    for (int r = 0; r < 30; r++) begin
      do_run(r % 2, int'($urandom_range(0, 4)), 1'b1, edges, seq);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
